// File: rtl/cgol_pkg.sv
// Shared constants, types and helpers for the CGOL row fetcher.
package cgol_pkg;

  localparam int MAX_WIDTH       = 256;
  localparam int MAX_HEIGHT      = 256;
  localparam int MAX_WIDTH_BYTES = MAX_WIDTH / 8;
  localparam int XMEM_ADDR_WIDTH = 16;
  // Wide enough to carry a full row byte count (MAX_WIDTH_BYTES itself).
  localparam int MEM_SIZE_WIDTH  = $clog2(MAX_WIDTH_BYTES + 1);

  typedef logic [MAX_WIDTH-1:0] cgol_row_t;
  // Byte 0 holds cells 0..7, bit b of byte k is cell 8*k+b.
  typedef logic [MAX_WIDTH_BYTES-1:0][7:0] mem_row_bytes_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH_CURR,
    ST_FETCH_NEXT,
    ST_PRESENT,
    ST_DONE
  } fetch_state_e;

  // A grid is legal when its width is a non-zero multiple of 8 within
  // MAX_WIDTH and its height lies in 1..MAX_HEIGHT.
  function automatic logic cfg_legal(input logic [8:0] width, input logic [8:0] height);
    return (width != 9'd0) && (width[2:0] == 3'd0) && (width <= 9'(MAX_WIDTH)) &&
           (height != 9'd0) && (height <= 9'(MAX_HEIGHT));
  endfunction

endpackage

// File: rtl/mem_intf_read.sv
// Row read interface between the fetcher (client) and XMEM (server).
interface mem_intf_read;

  logic                                   mem_req;
  logic [cgol_pkg::XMEM_ADDR_WIDTH-1:0]   mem_start_addr;
  logic [cgol_pkg::MEM_SIZE_WIDTH-1:0]    mem_size_bytes;
  logic                                   mem_valid;
  cgol_pkg::mem_row_bytes_t               mem_data;

  modport client_read (
    output mem_req,
    output mem_start_addr,
    output mem_size_bytes,
    input  mem_valid,
    input  mem_data
  );

  modport server_read (
    input  mem_req,
    input  mem_start_addr,
    input  mem_size_bytes,
    output mem_valid,
    output mem_data
  );

endinterface

// File: rtl/cgol_row_unpack.sv
// Converts a raw row of bytes into a cell row, zeroing every cell at or
// beyond the grid width so stale bytes never leak into the window.
module cgol_row_unpack
  import cgol_pkg::*;
(
  input  mem_row_bytes_t mem_data,
  input  logic [8:0]     width,
  output cgol_row_t      row
);

  localparam cgol_row_t ALL_ONES = '1;

  // Shifting by width >= MAX_WIDTH yields zero, so the mask becomes all ones.
  always_comb begin
    row = cgol_row_t'(mem_data) & ~(ALL_ONES << width);
  end

endmodule

// File: rtl/cgol_row_fetcher.sv
// Fetches grid rows from XMEM one at a time and presents a zero-padded
// prev/curr/next window per output row over a valid/ready handshake.
module cgol_row_fetcher
  import cgol_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [XMEM_ADDR_WIDTH-1:0] base_addr,
  input  logic [8:0]                 width,
  input  logic [8:0]                 height,
  mem_intf_read.client_read          mem_intf_read,
  output logic                       win_valid,
  input  logic                       win_ready,
  output cgol_row_t                  win_prev,
  output cgol_row_t                  win_curr,
  output cgol_row_t                  win_next,
  output logic [7:0]                 win_row_idx,
  output logic                       win_last,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  fetch_state_e               state_q, state_d;
  logic [XMEM_ADDR_WIDTH-1:0] fetch_addr_q;
  logic [MEM_SIZE_WIDTH-1:0]  row_bytes_q;
  logic [8:0]                 width_q, height_q;
  cgol_row_t                  prev_q, curr_q, next_q;
  cgol_row_t                  row_in;
  logic [7:0]                 row_idx_q;
  logic                       cfg_err_q;

  logic load_cfg, take_curr, take_next, shift_win, clear_next;
  logic is_last, next_is_last;

  cgol_row_unpack u_unpack (
    .mem_data (mem_intf_read.mem_data),
    .width    (width_q),
    .row      (row_in)
  );

  // Current row is the last one; the following row would be the last one.
  assign is_last      = ({1'b0, row_idx_q} + 9'd1) == height_q;
  assign next_is_last = ({1'b0, row_idx_q} + 9'd2) == height_q;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and datapath control strobes.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    load_cfg   = 1'b0;
    take_curr  = 1'b0;
    take_next  = 1'b0;
    shift_win  = 1'b0;
    clear_next = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && cfg_legal(width, height)) begin
          load_cfg = 1'b1;
          state_d  = ST_FETCH_CURR;
        end
      end
      ST_FETCH_CURR: begin
        if (mem_intf_read.mem_valid) begin
          take_curr = 1'b1;
          if (height_q > 9'd1) begin
            state_d = ST_FETCH_NEXT;
          end else begin
            clear_next = 1'b1;
            state_d    = ST_PRESENT;
          end
        end
      end
      ST_FETCH_NEXT: begin
        if (mem_intf_read.mem_valid) begin
          take_next = 1'b1;
          state_d   = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (win_ready) begin
          if (is_last) begin
            state_d = ST_DONE;
          end else begin
            shift_win = 1'b1;
            // The bottom border needs no fetch: pad with zeros and stay.
            if (next_is_last) clear_next = 1'b1;
            else              state_d    = ST_FETCH_NEXT;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Configuration, fetch address accumulation and the three-row window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_addr_q <= '0;
      row_bytes_q  <= '0;
      width_q      <= '0;
      height_q     <= '0;
      prev_q       <= '0;
      curr_q       <= '0;
      next_q       <= '0;
      row_idx_q    <= '0;
    end else begin
      if (load_cfg) begin
        fetch_addr_q <= base_addr;
        row_bytes_q  <= MEM_SIZE_WIDTH'(width >> 3);
        width_q      <= width;
        height_q     <= height;
        prev_q       <= '0;
        curr_q       <= '0;
        next_q       <= '0;
        row_idx_q    <= '0;
      end
      if (take_curr) begin
        curr_q       <= row_in;
        fetch_addr_q <= fetch_addr_q + XMEM_ADDR_WIDTH'(row_bytes_q);
      end
      if (take_next) begin
        next_q       <= row_in;
        fetch_addr_q <= fetch_addr_q + XMEM_ADDR_WIDTH'(row_bytes_q);
      end
      if (shift_win) begin
        prev_q    <= curr_q;
        curr_q    <= next_q;
        row_idx_q <= row_idx_q + 8'd1;
      end
      if (clear_next) next_q <= '0;
    end
  end

  // Illegal-config pulse, raised the cycle after the offending start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cfg_err_q <= 1'b0;
    else        cfg_err_q <= (state_q == ST_IDLE) && start && !cfg_legal(width, height);
  end

  assign mem_intf_read.mem_req        = (state_q == ST_FETCH_CURR) || (state_q == ST_FETCH_NEXT);
  assign mem_intf_read.mem_start_addr = fetch_addr_q;
  assign mem_intf_read.mem_size_bytes = row_bytes_q;

  assign win_valid   = (state_q == ST_PRESENT);
  assign win_prev    = prev_q;
  assign win_curr    = curr_q;
  assign win_next    = next_q;
  assign win_row_idx = row_idx_q;
  assign win_last    = win_valid && is_last;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_cgol_row_fetcher.sv
// Directed bench for cgol_row_fetcher with a fixed-latency XMEM model.
module tb_cgol_row_fetcher;
  import cgol_pkg::*;

  localparam int RD_LAT = 2;

  logic                       clk;
  logic                       rst_n;
  logic                       start;
  logic [XMEM_ADDR_WIDTH-1:0] base_addr;
  logic [8:0]                 width;
  logic [8:0]                 height;
  logic                       win_valid;
  logic                       win_ready;
  cgol_row_t                  win_prev, win_curr, win_next;
  logic [7:0]                 win_row_idx;
  logic                       win_last;
  logic                       busy;
  logic                       done;
  logic                       cfg_err;

  mem_intf_read mem_if ();

  cgol_row_fetcher dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .base_addr     (base_addr),
    .width         (width),
    .height        (height),
    .mem_intf_read (mem_if),
    .win_valid     (win_valid),
    .win_ready     (win_ready),
    .win_prev      (win_prev),
    .win_curr      (win_curr),
    .win_next      (win_next),
    .win_row_idx   (win_row_idx),
    .win_last      (win_last),
    .busy          (busy),
    .done          (done),
    .cfg_err       (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks    = 0;
  int failures  = 0;

  logic [7:0]  xmem [0:4095];
  logic [15:0] rd_addr [0:63];
  int          rd_size [0:63];
  int          rd_count   = 0;
  int          done_count = 0;
  int          lat_cnt    = 0;

  // XMEM model: answers a held request RD_LAT negedges later with a one-cycle
  // mem_valid. Bytes beyond the requested size read as 0xFF.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_if.mem_valid = 1'b0;
      lat_cnt = 0;
    end else if (mem_if.mem_valid) begin
      mem_if.mem_valid = 1'b0;
      lat_cnt = 0;
    end else if (mem_if.mem_req) begin
      lat_cnt++;
      if (lat_cnt >= RD_LAT) begin
        for (int i = 0; i < MAX_WIDTH_BYTES; i++) begin
          if (i < int'(mem_if.mem_size_bytes))
            mem_if.mem_data[i] = xmem[(int'(mem_if.mem_start_addr) + i) % 4096];
          else
            mem_if.mem_data[i] = 8'hFF;
        end
        if (rd_count < 64) begin
          rd_addr[rd_count] = mem_if.mem_start_addr;
          rd_size[rd_count] = int'(mem_if.mem_size_bytes);
        end
        rd_count++;
        mem_if.mem_valid = 1'b1;
      end
    end
  end

  // done pulses are counted once each, away from the active edge.
  always @(negedge clk) begin
    if (done) done_count++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [8:0] w, input logic [8:0] h);
    base_addr = b;
    width     = w;
    height    = h;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Waits (bounded) for a window and checks every field of it.
  task automatic expect_window(input string tag, input cgol_row_t p, input cgol_row_t c,
                               input cgol_row_t n, input int idx, input bit last,
                               input bit already_here);
    int k = 0;
    if (!already_here) @(negedge clk);
    while (!win_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, win_valid, 1'b1);
    check({tag, "_prev"}, win_prev, p);
    check({tag, "_curr"}, win_curr, c);
    check({tag, "_next"}, win_next, n);
    check({tag, "_idx_last"}, {win_row_idx, win_last}, {8'(idx), last});
  endtask

  task automatic expect_done(input string tag, input int exp_total);
    repeat (20) @(negedge clk);
    check({tag, "_done_count"}, done_count, exp_total);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic load_grid4();
    for (int k = 0; k < 4; k++) begin
      xmem[16'h200 + 2 * k]     = 8'(1 << k);
      xmem[16'h200 + 2 * k + 1] = 8'h00;
    end
  endtask

  initial begin
    int rd_base;
    int dc;
    cgol_row_t z;
    z = '0;

    for (int i = 0; i < 4096; i++) xmem[i] = 8'h00;
    mem_if.mem_valid = 1'b0;
    mem_if.mem_data  = '0;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    width     = '0;
    height    = '0;
    win_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("reset_ctrl", {win_valid, mem_if.mem_req, busy, done, cfg_err, win_last}, 6'b0);
    check("reset_window", {win_prev[7:0], win_curr[7:0], win_next[7:0], win_row_idx}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ctrl", {win_valid, mem_if.mem_req, busy, done, cfg_err}, 5'b0);

    // Single 8-cell row.
    xmem[16'h100] = 8'hA5;
    rd_base = rd_count;
    pulse_start(16'h100, 9'd8, 9'd1);
    check("t1_busy", busy, 1'b1);
    expect_window("t1_r0", z, 256'hA5, z, 0, 1'b1, 1'b0);
    expect_done("t1", 1);
    check("t1_reads", rd_count - rd_base, 1);
    check("t1_rd_addr", rd_addr[rd_base], 16'h100);
    check("t1_rd_size", rd_size[rd_base], 1);

    // Four 16-cell rows, consumer always ready.
    load_grid4();
    rd_base = rd_count;
    pulse_start(16'h200, 9'd16, 9'd4);
    expect_window("t2_r0", z, 256'h1, 256'h2, 0, 1'b0, 1'b0);
    expect_window("t2_r1", 256'h1, 256'h2, 256'h4, 1, 1'b0, 1'b0);
    expect_window("t2_r2", 256'h2, 256'h4, 256'h8, 2, 1'b0, 1'b0);
    expect_window("t2_r3", 256'h4, 256'h8, z, 3, 1'b1, 1'b0);
    expect_done("t2", 2);
    check("t2_reads", rd_count - rd_base, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_rd%0d_addr", k), rd_addr[rd_base + k], 16'h200 + 16'(2 * k));
      check($sformatf("t2_rd%0d_size", k), rd_size[rd_base + k], 2);
    end

    // Same grid, consumer stalls for 20 cycles on row 1.
    rd_base = rd_count;
    win_ready = 1'b0;
    pulse_start(16'h200, 9'd16, 9'd4);
    expect_window("t3_r0", z, 256'h1, 256'h2, 0, 1'b0, 1'b0);
    win_ready = 1'b1;
    @(negedge clk);
    win_ready = 1'b0;
    expect_window("t3_r1", 256'h1, 256'h2, 256'h4, 1, 1'b0, 1'b0);
    dc = rd_count;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("t3_stall%0d_ctrl", k), {win_valid, mem_if.mem_req, win_row_idx}, {1'b1, 1'b0, 8'd1});
      check($sformatf("t3_stall%0d_win", k), {win_prev[15:0], win_curr[15:0], win_next[15:0]},
            {16'h1, 16'h2, 16'h4});
    end
    check("t3_stall_no_reads", rd_count, dc);
    win_ready = 1'b1;
    expect_window("t3_r2", 256'h2, 256'h4, 256'h8, 2, 1'b0, 1'b0);
    expect_window("t3_r3", 256'h4, 256'h8, z, 3, 1'b1, 1'b0);
    expect_done("t3", 3);
    check("t3_reads", rd_count - rd_base, 4);

    // Illegal configurations.
    rd_base = rd_count;
    pulse_start(16'h200, 9'd12, 9'd4);
    check("t4_w12_cfg_err", {cfg_err, busy}, 2'b10);
    @(negedge clk);
    check("t4_w12_pulse_end", {cfg_err, busy}, 2'b00);
    pulse_start(16'h200, 9'd0, 9'd4);
    check("t4_w0_cfg_err", {cfg_err, busy}, 2'b10);
    @(negedge clk);
    check("t4_w0_pulse_end", {cfg_err, busy}, 2'b00);
    pulse_start(16'h200, 9'd16, 9'd0);
    check("t4_h0_cfg_err", {cfg_err, busy}, 2'b10);
    @(negedge clk);
    check("t4_h0_pulse_end", {cfg_err, busy, mem_if.mem_req}, 3'b000);
    repeat (5) @(negedge clk);
    check("t4_no_reads", rd_count, rd_base);

    // Second start mid-run is ignored.
    rd_base = rd_count;
    pulse_start(16'h200, 9'd16, 9'd4);
    expect_window("t5_r0", z, 256'h1, 256'h2, 0, 1'b0, 1'b0);
    expect_window("t5_r1", 256'h1, 256'h2, 256'h4, 1, 1'b0, 1'b0);
    expect_window("t5_r2", 256'h2, 256'h4, 256'h8, 2, 1'b0, 1'b0);
    pulse_start(16'h300, 9'd8, 9'd1);
    base_addr = 16'h200;
    width     = 9'd16;
    height    = 9'd4;
    expect_window("t5_r3", 256'h4, 256'h8, z, 3, 1'b1, 1'b1);
    expect_done("t5", 4);
    check("t5_reads", rd_count - rd_base, 4);
    for (int k = 0; k < 4; k++)
      check($sformatf("t5_rd%0d_addr", k), rd_addr[rd_base + k], 16'h200 + 16'(2 * k));

    // Asynchronous reset while a FETCH_NEXT read is outstanding.
    pulse_start(16'h200, 9'd16, 9'd4);
    expect_window("t6_r0", z, 256'h1, 256'h2, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_req_before_reset", mem_if.mem_req, 1'b1);
    dc = done_count;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_ctrl", {win_valid, mem_if.mem_req, busy, done, cfg_err, win_last, win_row_idx}, 14'b0);
    check("t6_async_curr", win_curr, z);
    check("t6_async_prev_next", {win_prev[127:0], win_next[127:0]}, 256'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_no_done", done_count, dc);
    xmem[16'h100] = 8'hA5;
    xmem[16'h101] = 8'h3C;
    rd_base = rd_count;
    pulse_start(16'h100, 9'd8, 9'd2);
    expect_window("t6_r0", z, 256'hA5, 256'h3C, 0, 1'b0, 1'b0);
    expect_window("t6_r1", 256'hA5, 256'h3C, z, 1, 1'b1, 1'b0);
    expect_done("t6", dc + 1);
    check("t6_reads", rd_count - rd_base, 2);
    check("t6_rd0_addr", rd_addr[rd_base], 16'h100);
    check("t6_rd1_addr", rd_addr[rd_base + 1], 16'h101);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cgol_row_fetcher.md
Name: cgol_row_fetcher

Overview:
Upstream feeder for the CGOL calculation stage. Reads grid rows from XMEM over the read memory interface, one row per request. Maintains a sliding three-row window (prev/curr/next) with zero padding at the top and bottom borders. Presents one window per output row to the downstream consumer over a valid/ready handshake, so the calculator never touches the read interface itself.

Parameters:
MAX_WIDTH, 256, max cells per row; must be a multiple of 8.
MAX_HEIGHT, 256, max rows per grid.
MAX_WIDTH_BYTES, MAX_WIDTH/8, derived; row byte count upper bound.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous active-low reset.
start  in  1  single-cycle start pulse; sampled only in IDLE.
base_addr  in  XMEM_ADDR_WIDTH  grid base address; latched on accepted start.
width  in  9  grid width in cells, 8..MAX_WIDTH, multiple of 8; latched on start.
height  in  9  grid height in rows, 1..MAX_HEIGHT; latched on start.
mem_intf_read  modport  mem_intf_read.client_read  row reads: mem_req, mem_start_addr, mem_size_bytes, mem_valid, mem_data.
win_valid  out  1  window presented.
win_ready  in  1  consumer accepts window.
win_prev  out  MAX_WIDTH  row r-1, or 0 when r=0.
win_curr  out  MAX_WIDTH  row r.
win_next  out  MAX_WIDTH  row r+1, or 0 when r=height-1.
win_row_idx  out  8  r, the index of win_curr.
win_last  out  1  high when r=height-1.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse after the last window is accepted.
cfg_err  out  1  one-cycle pulse when start carries an illegal config.

Behaviour:
- Reset: all outputs 0; mem_req=0; window registers and state cleared. Reset mid-operation aborts immediately with no completion pulse.
- Cell mapping: column c = mem_data[c>>3][c&7]. Output bits at or above width are forced to 0.
- Row geometry: row_bytes = width>>3. mem_size_bytes = row_bytes. Fetch k uses address base_addr + k*row_bytes, built by accumulation modulo 2^XMEM_ADDR_WIDTH, with no multiplier.
- Config check on start: width=0, width[2:0]!=0, width>MAX_WIDTH, height=0 or height>MAX_HEIGHT all cause a cfg_err pulse next cycle and no state change.
- Start is ignored while busy.
- States:
  - IDLE: a legal start goes to FETCH_CURR. It clears prev, sets r=0 and sets fetch address = base_addr.
  - FETCH_CURR: mem_req=1 until mem_valid. On mem_valid, the row goes to curr and the address advances. Next state is FETCH_NEXT if height>1; otherwise next=0 and state goes to PRESENT.
  - FETCH_NEXT: mem_req=1 until mem_valid. On mem_valid, the row goes to next, the address advances, and state goes to PRESENT.
  - PRESENT: win_valid=1 and mem_req=0. Window outputs are held stable until accepted. On win_valid&&win_ready:
    - If win_last, go to DONE.
    - Otherwise shift prev<=curr, curr<=next and r<=r+1.
    - If the new r equals height-1, set next<=0 and stay in PRESENT (no fetch). Otherwise go to FETCH_NEXT.
  - DONE: done=1 for one cycle, then IDLE.
- Read handshake:
  - mem_req is a registered-state decode, held continuously until the mem_valid cycle.
  - mem_data is sampled only in the mem_valid cycle.
  - mem_valid outside the FETCH states is ignored.
  - mem_start_addr and mem_size_bytes are stable while mem_req=1.
- Minimum latency:
  - start to first win_valid = 1 + (rd latency+1) * min(height,2) cycles.
  - Each subsequent window costs one read latency plus 1 cycle, except the final window, which needs no fetch.
- win_ready held high in the same cycle win_valid rises: the window is accepted that cycle. win_ready low stalls indefinitely with no read traffic.
- At most one outstanding read; total reads per run = height.

Decomposition:
- Shared package cgol_pkg: MAX_WIDTH, MAX_HEIGHT, MAX_WIDTH_BYTES, cgol_row_t (logic [MAX_WIDTH-1:0]), fetcher state enum.
- One sub-module: cgol_row_unpack. It is combinational and converts the mem_data byte array plus width into a masked cgol_row_t. It is instantiated once, on the read data path.

Test Plan:
- width=8, height=1, base=0x100, row byte 0xA5, win_ready=1:
  - Exactly one read at 0x100, size 1.
  - One window: prev=0, curr=0xA5, next=0, win_last=1.
  - done pulses once.
- width=16, height=4, base=0x200, rows 0x0001/0x0002/0x0004/0x0008:
  - Reads at 0x200, 0x202, 0x204, 0x206.
  - Windows r=0..3 show prev/curr/next equal to (0,1,2), (1,2,4), (2,4,8), (4,8,0).
- Same grid with win_ready low for 20 cycles at r=1:
  - win_valid and window outputs stay stable.
  - mem_req stays 0 during the stall.
  - No extra reads are issued.
- width=12 start, then width=0 start, then height=0 start:
  - Each produces a cfg_err pulse; busy stays 0 and there is no read.
- Second start pulse mid-run (at r=2 of a 4-row grid) is ignored:
  - Addresses are unchanged and done still occurs once.
- rst_n asserted while mem_req=1 in FETCH_NEXT:
  - All outputs go to 0 asynchronously, with no done.
  - A fresh start afterwards (width=8, height=2) completes normally from base_addr.
